// File: rtl/seg2hex_capture.sv
// rtl/seg2hex_capture.sv - capture and decode a multiplexed 7-segment display bus into per-digit hex values
module seg2hex_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd,
    output logic [2:0]              upd_idx
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam int SW = NUM_DIGITS + 7;

    typedef enum logic [1:0] {IDLE, ACQ, HELD} state_t;

    state_t                state, state_nxt;
    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2;
    logic [SW-1:0]         samp, samp_prev;
    logic [CW-1:0]         cnt;
    logic                  changed, commit, new_onehot;
    logic [2:0]            idx;
    logic [4:0]            dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = 5'h10;
            7'h30: decode = 5'h11;
            7'h6D: decode = 5'h12;
            7'h79: decode = 5'h13;
            7'h33: decode = 5'h14;
            7'h5B: decode = 5'h15;
            7'h5F: decode = 5'h16;
            7'h70: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h7B: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h1F: decode = 5'h1B;
            7'h4E: decode = 5'h1C;
            7'h3D: decode = 5'h1D;
            7'h4F: decode = 5'h1E;
            7'h47: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign samp    = {sel_s2, seg_s2};
    assign changed = (samp != samp_prev);
    assign new_onehot = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - 1'b1)) == '0);
    // The counted value lives in samp_prev, so the commit uses it even if samp moves this cycle.
    assign commit  = (state == ACQ) && (cnt == CNT_MAX);
    assign dec     = decode(samp_prev[6:0]);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (samp_prev[7+i]) idx = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        if (changed)     state_nxt = new_onehot ? ACQ : IDLE;
        else if (commit) state_nxt = HELD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1    <= '0;
            seg_s2    <= '0;
            sel_s1    <= '0;
            sel_s2    <= '0;
            samp_prev <= '0;
            cnt       <= '0;
            state     <= IDLE;
        end else begin
            seg_s1    <= seg_in;
            seg_s2    <= seg_s1;
            sel_s1    <= dig_sel;
            sel_s2    <= sel_s1;
            samp_prev <= samp;
            state     <= state_nxt;
            if (changed)             cnt <= CW'(1);
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out     <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
        end else begin
            upd <= commit;
            if (commit) begin
                upd_idx <= idx;
                if (dec[4]) begin
                    hex_out[4*idx +: 4] <= dec[3:0];
                    digit_valid[idx]    <= 1'b1;
                    digit_err[idx]      <= 1'b0;
                end else begin
                    digit_valid[idx]    <= 1'b0;
                    digit_err[idx]      <= (samp_prev[6:0] != 7'h00);
                end
            end
        end
    end
endmodule

// File: tb/tb_seg2hex_capture.sv
// tb/tb_seg2hex_capture.sv - scoreboard bench for seg2hex_capture
module tb_seg2hex_capture;
    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] digit_valid, digit_err;
    logic          upd;
    logic [2:0]    upd_idx;

    seg2hex_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
        .hex_out(hex_out), .digit_valid(digit_valid), .digit_err(digit_err),
        .upd(upd), .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      idx;
        logic [4*ND-1:0] hex;
        logic [ND-1:0]   valid;
        logic [ND-1:0]   err;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    logic [4*ND-1:0] m_hex = '0;
    logic [ND-1:0]   m_valid = '0;
    logic [ND-1:0]   m_err = '0;
    logic [6:0]      codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (upd === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_upd", upd, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_idx", upd_idx, e.idx);
                check("hex_out", hex_out, e.hex);
                check("digit_valid", digit_valid, e.valid);
                check("digit_err", digit_err, e.err);
            end
        end
    end

    // Drive a pattern at the pins and hold it for n cycles; when a commit is
    // expected, apply it to the model and push a snapshot of the outputs.
    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n, input bit expect_commit);
        @(negedge clk);
        dig_sel = sel;
        seg_in  = seg;
        if (expect_commit) begin
            exp_t e;
            int   d;
            int   v;
            d = 0;
            v = -1;
            for (int i = 0; i < ND; i++) if (sel[i]) d = i;
            for (int k = 0; k < 16; k++) if (codes[k] == seg) v = k;
            if (v >= 0) begin
                m_hex[4*d +: 4] = 4'(v);
                m_valid[d] = 1'b1;
                m_err[d]   = 1'b0;
            end else begin
                m_valid[d] = 1'b0;
                m_err[d]   = (seg != 7'h00);
            end
            e.idx = 3'(d);
            e.hex = m_hex;
            e.valid = m_valid;
            e.err = m_err;
            e.cyc = cyc + SC + 3;
            sb.push_back(e);
        end
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_hex"}, hex_out, 0);
        check({tag, "_valid"}, digit_valid, 0);
        check({tag, "_err"}, digit_err, 0);
        check({tag, "_upd"}, upd, 0);
    endtask

    initial begin
        rst = 1'b1;
        seg_in = 7'h00;
        dig_sel = '0;
        #1 check_cleared("reset_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        hold(4'b0001, 7'h6D, 20, 1);
        hold(4'b0001, 7'h30, 3, 0);
        hold(4'b0001, 7'h79, 20, 1);
        hold(4'b0100, 7'h01, 20, 1);
        hold(4'b0100, 7'h47, 20, 1);
        hold(4'b0011, 7'h7E, 30, 0);
        hold(4'b0010, 7'h00, 20, 1);

        for (int s = 0; s < 2; s++) begin
            hold(4'b0001, 7'h30, 8, 1);
            hold(4'b0010, 7'h77, 8, 1);
            hold(4'b0100, 7'h4E, 8, 1);
            hold(4'b1000, 7'h70, 8, 1);
        end
        check("scan_hex", hex_out, 16'h7CA1);
        check("scan_valid", digit_valid, 4'hF);

        hold(4'b0001, 7'h30, 8, 1);
        hold(4'b0010, 7'h77, 8, 1);
        hold(4'b0100, 7'h4E, 3, 0);
        #2 rst = 1'b1;
        #1 check_cleared("reset_mid");
        m_hex = '0;
        m_valid = '0;
        m_err = '0;
        check("pending_after_reset", sb.size(), 0);
        dig_sel = '0;
        seg_in = 7'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(4'b0100, 7'h4E, 8, 1);
        hold(4'b1000, 7'h70, 8, 1);
        hold(4'b0001, 7'h30, 8, 1);
        hold(4'b0010, 7'h77, 8, 1);
        hold(4'b0000, 7'h00, 10, 0);

        check("pending_at_end", sb.size(), 0);
        check("final_hex", hex_out, 16'h7CA1);
        check("final_valid", digit_valid, 4'hF);
        check("final_err", digit_err, 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
